// File: rtl/store_buffer_pkg.sv
// Shared sizes, entry layout and lane-merge helper for the store buffer.
package store_buffer_pkg;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 30;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(DEPTH);
  // Merging into the newest entry is only safe when it is not also the head,
  // otherwise the bus could see its fields change while presented.
  localparam logic [CNT_W-1:0] CNT_MERGE_MIN = CNT_W'(2);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    byteen;
    logic [31:0]   wdata;
  } entry_t;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_d,
                                              input logic [31:0] new_d,
                                              input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store/load request side and memory bus side of the store buffer.
interface store_buffer_if;

  logic                             st_en;
  logic [store_buffer_pkg::AW-1:0]  st_addr;
  logic [3:0]                       st_byteen;
  logic [31:0]                      st_wdata;
  logic                             st_stall;

  logic                             ld_en;
  logic [store_buffer_pkg::AW-1:0]  ld_addr;
  logic [3:0]                       ld_byteen;
  logic                             ld_stall;

  logic                             bus_valid;
  logic                             bus_ready;
  logic [store_buffer_pkg::AW-1:0]  bus_addr;
  logic [3:0]                       bus_byteen;
  logic [31:0]                      bus_wdata;

  logic                             empty;

  modport master (
    output st_en, st_addr, st_byteen, st_wdata,
    input  st_stall,
    output ld_en, ld_addr, ld_byteen,
    input  ld_stall,
    input  bus_valid, bus_addr, bus_byteen, bus_wdata,
    output bus_ready,
    input  empty
  );

  modport slave (
    input  st_en, st_addr, st_byteen, st_wdata,
    output st_stall,
    input  ld_en, ld_addr, ld_byteen,
    output ld_stall,
    output bus_valid, bus_addr, bus_byteen, bus_wdata,
    input  bus_ready,
    output empty
  );

endinterface

// File: rtl/store_buffer_hazard_cmp.sv
// RAW check of one buffer entry against the current load.
module store_buffer_hazard_cmp
  import store_buffer_pkg::*;
(
  input  logic [AW-1:0] ent_addr,
  input  logic [3:0]    ent_byteen,
  input  logic          live,
  input  logic [AW-1:0] ld_addr,
  input  logic [3:0]    ld_byteen,
  output logic          hit
);

  assign hit = live & (ent_addr == ld_addr) & (|(ent_byteen & ld_byteen));

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: in-order drain, merge into newest entry, full and RAW stalls.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave sb
);

  entry_t            entries [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  newest;
  logic [CNT_W-1:0]  count;
  logic              has_st;
  logic              merge;
  logic              enq;
  logic              pop;
  logic [DEPTH-1:0]  hits;

  assign newest = tail - 1'b1;
  assign has_st = sb.st_en & (|sb.st_byteen);
  assign merge  = has_st & (count >= CNT_MERGE_MIN) & (entries[newest].addr == sb.st_addr);
  assign enq    = has_st & ~merge & (count != CNT_FULL);
  assign pop    = sb.bus_valid & sb.bus_ready;

  assign sb.st_stall   = has_st & ~merge & (count == CNT_FULL);
  assign sb.bus_valid  = (count != '0);
  assign sb.empty      = (count == '0);
  assign sb.bus_addr   = sb.bus_valid ? entries[head].addr   : '0;
  assign sb.bus_byteen = sb.bus_valid ? entries[head].byteen : '0;
  assign sb.bus_wdata  = sb.bus_valid ? entries[head].wdata  : '0;
  assign sb.ld_stall   = sb.ld_en & (|hits);

  for (genvar k = 0; k < DEPTH; k++) begin : g_hz
    logic [PTR_W-1:0] offs;
    logic             live;
    assign offs = PTR_W'(k) - head;
    assign live = ({1'b0, offs} < count);
    store_buffer_hazard_cmp u_cmp (
      .ent_addr   (entries[k].addr),
      .ent_byteen (entries[k].byteen),
      .live       (live),
      .ld_addr    (sb.ld_addr),
      .ld_byteen  (sb.ld_byteen),
      .hit        (hits[k])
    );
  end

  // Pointer, occupancy and entry storage update for enqueue, merge and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (pop) begin
        head <= head + 1'b1;
      end
      if (enq) begin
        entries[tail] <= '{addr: sb.st_addr, byteen: sb.st_byteen, wdata: sb.st_wdata};
        tail          <= tail + 1'b1;
      end
      if (merge) begin
        entries[newest].byteen <= entries[newest].byteen | sb.st_byteen;
        entries[newest].wdata  <= merge_lanes(entries[newest].wdata, sb.st_wdata, sb.st_byteen);
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue model of the pending entries.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic clk = 1'b0;
  logic reset;

  store_buffer_if sb_if ();

  store_buffer u_dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  always #5 clk = ~clk;

  int     vectors     = 0;
  int     miscompares = 0;
  entry_t exp_q[$];
  logic   last_exp_stall;
  logic   obs_st_stall;
  logic   obs_ld_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_st(input logic en, input logic [AW-1:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    sb_if.st_en     = en;
    sb_if.st_addr   = a;
    sb_if.st_byteen = be;
    sb_if.st_wdata  = d;
  endtask

  task automatic set_ld(input logic en, input logic [AW-1:0] a, input logic [3:0] be);
    sb_if.ld_en     = en;
    sb_if.ld_addr   = a;
    sb_if.ld_byteen = be;
  endtask

  // One clock: check outputs at the falling edge against the model, then advance the model.
  task automatic tick();
    logic   has_st;
    logic   exp_merge;
    logic   exp_stall;
    logic   exp_ld;
    entry_t e;
    @(negedge clk);
    chk("bus_valid", 32'(sb_if.bus_valid), 32'(exp_q.size() != 0));
    chk("empty", 32'(sb_if.empty), 32'(exp_q.size() == 0));
    if (exp_q.size() != 0) begin
      chk("bus_addr", 32'(sb_if.bus_addr), 32'(exp_q[0].addr));
      chk("bus_byteen", 32'(sb_if.bus_byteen), 32'(exp_q[0].byteen));
      chk("bus_wdata", sb_if.bus_wdata, exp_q[0].wdata);
    end
    has_st    = sb_if.st_en && (sb_if.st_byteen != 4'b0000);
    exp_merge = has_st && (exp_q.size() >= 2) && (exp_q[exp_q.size()-1].addr == sb_if.st_addr);
    exp_stall = has_st && !exp_merge && (exp_q.size() == DEPTH);
    obs_st_stall = sb_if.st_stall;
    if (sb_if.st_en) chk("st_stall", 32'(sb_if.st_stall), 32'(exp_stall));
    obs_ld_stall = sb_if.ld_stall;
    if (sb_if.ld_en) begin
      exp_ld = 1'b0;
      foreach (exp_q[k]) begin
        if (exp_q[k].addr == sb_if.ld_addr && (exp_q[k].byteen & sb_if.ld_byteen) != 4'b0000)
          exp_ld = 1'b1;
      end
      chk("ld_stall", 32'(sb_if.ld_stall), 32'(exp_ld));
    end
    last_exp_stall = exp_stall;
    if (sb_if.bus_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (exp_merge) begin
      e = exp_q[exp_q.size()-1];
      for (int i = 0; i < 4; i++) begin
        if (sb_if.st_byteen[i]) begin
          e.byteen[i]       = 1'b1;
          e.wdata[8*i +: 8] = sb_if.st_wdata[8*i +: 8];
        end
      end
      exp_q[exp_q.size()-1] = e;
    end else if (has_st && !exp_stall) begin
      exp_q.push_back('{addr: sb_if.st_addr, byteen: sb_if.st_byteen, wdata: sb_if.st_wdata});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    sb_if.bus_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    chk("drain_empty", 32'(sb_if.empty), 32'd1);
  endtask

  initial begin
    logic [AW-1:0] a;
    reset = 1'b0;
    set_st(1'b1, 30'h10, 4'hF, 32'h0);
    set_ld(1'b1, 30'h10, 4'hF);
    sb_if.bus_ready = 1'b1;
    #12;
    chk("rst_bus_valid", 32'(sb_if.bus_valid), 32'd0);
    chk("rst_empty", 32'(sb_if.empty), 32'd1);
    chk("rst_st_stall", 32'(sb_if.st_stall), 32'd0);
    chk("rst_ld_stall", 32'(sb_if.ld_stall), 32'd0);
    chk("rst_bus_addr", 32'(sb_if.bus_addr), 32'd0);
    chk("rst_bus_byteen", 32'(sb_if.bus_byteen), 32'd0);
    chk("rst_bus_wdata", sb_if.bus_wdata, 32'd0);
    set_st(1'b0, '0, 4'h0, '0);
    set_ld(1'b0, '0, 4'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single store passes straight through
    set_st(1'b1, 30'h10, 4'hF, 32'hAABBCCDD);
    tick();
    set_st(1'b0, '0, 4'h0, '0);
    tick();
    tick();

    // fill to full, fifth store stalls until a pop frees a slot
    sb_if.bus_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_st(1'b1, AW'(i), 4'hF, 32'h1000_0000 + i);
      tick();
    end
    set_st(1'b1, 30'h5, 4'hF, 32'h1000_0005);
    tick();
    chk("t2_full_stall", 32'(obs_st_stall), 32'd1);
    sb_if.bus_ready = 1'b1;
    tick();
    chk("t2_no_bypass", 32'(obs_st_stall), 32'd1);
    sb_if.bus_ready = 1'b0;
    tick();
    chk("t2_accept", 32'(obs_st_stall), 32'd0);
    set_st(1'b0, '0, 4'h0, '0);
    drain();

    // merge of same-word stores into the newest (non-head) entry
    sb_if.bus_ready = 1'b0;
    set_st(1'b1, 30'h7, 4'hF, 32'h07070707);
    tick();
    set_st(1'b1, 30'h8, 4'b0011, 32'h00001234);
    tick();
    set_st(1'b1, 30'h8, 4'b1100, 32'h56780000);
    tick();
    set_st(1'b1, 30'h9, 4'b0001, 32'h00000011);
    tick();
    set_st(1'b1, 30'h9, 4'b0000, 32'hFFFFFFFF);
    tick();
    set_st(1'b0, '0, 4'h0, '0);
    sb_if.bus_ready = 1'b1;
    tick();
    sb_if.bus_ready = 1'b0;
    tick();
    chk("t3_merged_addr", 32'(sb_if.bus_addr), 32'h8);
    chk("t3_merged_be", 32'(sb_if.bus_byteen), 32'hF);
    chk("t3_merged_data", sb_if.bus_wdata, 32'h56781234);
    drain();

    // RAW load hazard against a pending byte
    sb_if.bus_ready = 1'b0;
    set_st(1'b1, 30'h20, 4'b0001, 32'h000000AB);
    tick();
    set_st(1'b0, '0, 4'h0, '0);
    set_ld(1'b1, 30'h20, 4'b0001);
    tick();
    chk("t4_overlap", 32'(obs_ld_stall), 32'd1);
    set_ld(1'b1, 30'h20, 4'b0100);
    tick();
    chk("t4_disjoint", 32'(obs_ld_stall), 32'd0);
    set_ld(1'b1, 30'h21, 4'b0001);
    tick();
    chk("t4_other_word", 32'(obs_ld_stall), 32'd0);
    set_ld(1'b0, '0, 4'h0);
    drain();
    set_ld(1'b1, 30'h20, 4'b0001);
    tick();
    chk("t4_after_pop", 32'(obs_ld_stall), 32'd0);
    set_ld(1'b0, '0, 4'h0);

    // full buffer with continuous stores and continuous draining
    sb_if.bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_st(1'b1, AW'(30'h30 + i), 4'hF, 32'hC0DE_0030 + i);
      tick();
    end
    sb_if.bus_ready = 1'b1;
    a = 30'h40;
    set_st(1'b1, a, 4'hF, 32'hBEEF_0000 | 32'(a));
    tick();
    chk("t5_full_stall", 32'(obs_st_stall), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (!last_exp_stall) begin
        a = a + 1'b1;
        set_st(1'b1, a, 4'hF, 32'hBEEF_0000 | 32'(a));
      end
      tick();
    end
    set_st(1'b0, '0, 4'h0, '0);
    drain();

    // asynchronous reset with entries pending
    sb_if.bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_st(1'b1, AW'(30'h60 + i), 4'hF, 32'h6000_0000 + i);
      tick();
    end
    set_st(1'b0, '0, 4'h0, '0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(sb_if.bus_valid), 32'd0);
    chk("t6_rst_empty", 32'(sb_if.empty), 32'd1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb_if.bus_ready = 1'b1;
    set_st(1'b1, 30'h55, 4'hF, 32'h5555AAAA);
    tick();
    set_st(1'b0, '0, 4'h0, '0);
    @(negedge clk);
    chk("t6_new_addr", 32'(sb_if.bus_addr), 32'h55);
    chk("t6_new_data", sb_if.bus_wdata, 32'h5555AAAA);
    @(posedge clk);
    #1;
    void'(exp_q.pop_front());
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
